// File: rtl/host_if_slave.sv
// host_if_slave
//   Device-side responder for an 8080-style host bus. The asynchronous
//   strobes are synchronised into clk. Write bytes are captured and handed
//   on as one-cycle command/data strobes. Reads are served from the status
//   byte (a0=0) or from prefetched display data (a0=1).
//
// Ports
//   clk      in   system clock
//   rst_x    in   async reset, active low
//   cs_x     in   host chip select, low active (async)
//   a0       in   write: 1=command 0=data; read: 1=data 0=status
//   rd_x     in   host read strobe, low active (async)
//   wr_x     in   host write strobe, low active (async)
//   dat_i    in   [7:0] pad input data
//   dat_o    out  [7:0] pad output data
//   dat_oe   out  pad output enable, 1=drive
//   cmd_we   out  1-cycle pulse, wdata is a command byte
//   dat_we   out  1-cycle pulse, wdata is a parameter/data byte
//   wdata    out  [7:0] captured write byte, held until next capture
//   status   in   [7:0] status byte for a0=0 reads
//   rdata    in   [7:0] prefetched data for a0=1 reads
//   rd_ack   out  1-cycle pulse at end of an a0=1 read (advance prefetch)
//   bus_err  out  1-cycle pulse on protocol violation
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no strobe active, waiting for rd/wr
// WR_LOW  | write strobe low, timing the capture delay
// WR_HOLD | byte captured, waiting for the write strobe to rise
// RD_DRV  | read strobe low, driving status or read data onto the pads
// ERR     | protocol violation, waiting for both strobes to go high

module host_if_slave #(
   parameter int SYNC_STG = 2,
   parameter int CAP_DLY  = 2
) (
   input  logic       clk,
   input  logic       rst_x,
   input  logic       cs_x,
   input  logic       a0,
   input  logic       rd_x,
   input  logic       wr_x,
   input  logic [7:0] dat_i,
   output logic [7:0] dat_o,
   output logic       dat_oe,
   output logic       cmd_we,
   output logic       dat_we,
   output logic [7:0] wdata,
   input  logic [7:0] status,
   input  logic [7:0] rdata,
   output logic       rd_ack,
   output logic       bus_err
);

   localparam int CW = (CAP_DLY < 2) ? 1 : $clog2(CAP_DLY);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_LOW  = 3'd1,
      WR_HOLD = 3'd2,
      RD_DRV  = 3'd3,
      ERR     = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [SYNC_STG-1:0]   cs_sync_q, cs_sync_d;
   logic [SYNC_STG-1:0]   rd_sync_q, rd_sync_d;
   logic [SYNC_STG-1:0]   wr_sync_q, wr_sync_d;
   logic [CW-1:0]         lowcnt_q, lowcnt_d;
   logic [7:0]            wdata_q, wdata_d;
   logic                  a0_cap_q, a0_cap_d;
   logic [7:0]            dat_o_q, dat_o_d;
   logic                  dat_oe_q, dat_oe_d;
   logic                  cmd_we_q, cmd_we_d;
   logic                  dat_we_q, dat_we_d;
   logic                  rd_ack_q, rd_ack_d;
   logic                  bus_err_q, bus_err_d;

   logic cs_s, rd_s, wr_s;
   logic rd_act, wr_act;
   logic [7:0] rd_mux;

   always_comb begin
      cs_sync_d = {cs_sync_q[SYNC_STG-2:0], cs_x};
      rd_sync_d = {rd_sync_q[SYNC_STG-2:0], rd_x};
      wr_sync_d = {wr_sync_q[SYNC_STG-2:0], wr_x};
   end

   assign cs_s   = cs_sync_q[SYNC_STG-1];
   assign rd_s   = rd_sync_q[SYNC_STG-1];
   assign wr_s   = wr_sync_q[SYNC_STG-1];
   assign rd_act = ~rd_s & ~cs_s;
   assign wr_act = ~wr_s & ~cs_s;
   // a0 is sampled straight from the pad; the host holds it stable while a strobe is low
   assign rd_mux = a0 ? rdata : status;

   always_comb begin
      state_d   = state_q;
      lowcnt_d  = lowcnt_q;
      wdata_d   = wdata_q;
      a0_cap_d  = a0_cap_q;
      dat_o_d   = 8'h00;
      dat_oe_d  = 1'b0;
      cmd_we_d  = 1'b0;
      dat_we_d  = 1'b0;
      rd_ack_d  = 1'b0;
      bus_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr_act && rd_act) begin
               state_d   = ERR;
               bus_err_d = 1'b1;
            end else if (wr_act) begin
               // the IDLE cycle already counts as one low clock
               state_d  = WR_LOW;
               lowcnt_d = CW'(CAP_DLY - 1);
            end else if (rd_act) begin
               state_d  = RD_DRV;
               dat_oe_d = 1'b1;
               dat_o_d  = rd_mux;
            end
         end

         WR_LOW: begin
            if (cs_s) begin
               state_d   = IDLE;
               bus_err_d = 1'b1;
            end else if (wr_act && rd_act) begin
               state_d   = ERR;
               bus_err_d = 1'b1;
            end else if (!wr_act) begin
               state_d   = IDLE;
               bus_err_d = 1'b1;
            end else if (lowcnt_q == '0) begin
               state_d  = WR_HOLD;
               wdata_d  = dat_i;
               a0_cap_d = a0;
            end else begin
               lowcnt_d = lowcnt_q - 1'b1;
            end
         end

         WR_HOLD: begin
            if (cs_s) begin
               state_d   = IDLE;
               bus_err_d = 1'b1;
            end else if (wr_act && rd_act) begin
               state_d   = ERR;
               bus_err_d = 1'b1;
            end else if (!wr_act) begin
               state_d  = IDLE;
               cmd_we_d = a0_cap_q;
               dat_we_d = ~a0_cap_q;
            end
         end

         RD_DRV: begin
            if (cs_s) begin
               state_d   = IDLE;
               bus_err_d = 1'b1;
            end else if (wr_act && rd_act) begin
               state_d   = ERR;
               bus_err_d = 1'b1;
            end else if (!rd_act) begin
               state_d  = IDLE;
               rd_ack_d = a0;
            end else begin
               dat_oe_d = 1'b1;
               dat_o_d  = rd_mux;
            end
         end

         ERR: begin
            if (!rd_act && !wr_act) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         state_q   <= IDLE;
         cs_sync_q <= '1;
         rd_sync_q <= '1;
         wr_sync_q <= '1;
         lowcnt_q  <= '0;
         wdata_q   <= 8'h00;
         a0_cap_q  <= 1'b0;
         dat_o_q   <= 8'h00;
         dat_oe_q  <= 1'b0;
         cmd_we_q  <= 1'b0;
         dat_we_q  <= 1'b0;
         rd_ack_q  <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cs_sync_q <= cs_sync_d;
         rd_sync_q <= rd_sync_d;
         wr_sync_q <= wr_sync_d;
         lowcnt_q  <= lowcnt_d;
         wdata_q   <= wdata_d;
         a0_cap_q  <= a0_cap_d;
         dat_o_q   <= dat_o_d;
         dat_oe_q  <= dat_oe_d;
         cmd_we_q  <= cmd_we_d;
         dat_we_q  <= dat_we_d;
         rd_ack_q  <= rd_ack_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign dat_o   = dat_o_q;
   assign dat_oe  = dat_oe_q;
   assign cmd_we  = cmd_we_q;
   assign dat_we  = dat_we_q;
   assign wdata   = wdata_q;
   assign rd_ack  = rd_ack_q;
   assign bus_err = bus_err_q;

endmodule

// File: tb/tb_host_if_slave.sv
// tb_host_if_slave
//   Scoreboard bench for host_if_slave. Stimulus tasks push the events a host
//   transaction must produce (command/data strobe with byte, read drive with
//   byte, read ack, bus error) into a queue. A negedge monitor pops and
//   compares every time the DUT presents one of those outputs.

module tb_host_if_slave;

   localparam int SYNC_STG = 2;
   localparam int CAP_DLY  = 2;

   localparam logic [2:0] K_CMD = 3'd0;
   localparam logic [2:0] K_DAT = 3'd1;
   localparam logic [2:0] K_RD  = 3'd2;
   localparam logic [2:0] K_ACK = 3'd3;
   localparam logic [2:0] K_ERR = 3'd4;

   typedef struct packed {
      logic [2:0] kind;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_x = 1'b0;
   logic       cs_x = 1'b1;
   logic       a0 = 1'b0;
   logic       rd_x = 1'b1;
   logic       wr_x = 1'b1;
   logic [7:0] dat_i = 8'h00;
   logic [7:0] status = 8'h00;
   logic [7:0] rdata = 8'h00;
   logic [7:0] dat_o;
   logic       dat_oe;
   logic       cmd_we;
   logic       dat_we;
   logic [7:0] wdata;
   logic       rd_ack;
   logic       bus_err;

   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];
   logic oe_prev = 1'b0;

   host_if_slave #(.SYNC_STG(SYNC_STG), .CAP_DLY(CAP_DLY)) dut (
      .clk(clk), .rst_x(rst_x), .cs_x(cs_x), .a0(a0), .rd_x(rd_x), .wr_x(wr_x),
      .dat_i(dat_i), .dat_o(dat_o), .dat_oe(dat_oe), .cmd_we(cmd_we),
      .dat_we(dat_we), .wdata(wdata), .status(status), .rdata(rdata),
      .rd_ack(rd_ack), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] kind, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic got(input logic [2:0] kind, input logic [7:0] data);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event actual=kind%0d/%0h expected=none", kind, data);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== kind || e.data !== data) begin
            errors++;
            $display("FAIL event actual=kind%0d/%0h expected=kind%0d/%0h",
                     kind, data, e.kind, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (cmd_we)            got(K_CMD, wdata);
      if (dat_we)            got(K_DAT, wdata);
      if (dat_oe && !oe_prev) got(K_RD, dat_o);
      if (rd_ack)            got(K_ACK, 8'h00);
      if (bus_err)           got(K_ERR, 8'h00);
      oe_prev = dat_oe;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic a0v, input logic [7:0] b, input int len);
      int cnt;
      cs_x = 1'b0;
      tick(1);
      a0    = a0v;
      dat_i = b;
      wr_x  = 1'b0;
      tick(len);
      push(a0v ? K_CMD : K_DAT, b);
      wr_x = 1'b1;
      cnt = 0;
      do begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end while (!(cmd_we || dat_we) && cnt < 20);
      chk("we_latency", cnt, SYNC_STG + 1);
      tick(3);
      cs_x = 1'b1;
      tick(2);
   endtask

   task automatic host_read(input logic a0v, input logic [7:0] st, input logic [7:0] rd, input int len);
      logic [7:0] exp;
      exp    = a0v ? rd : st;
      status = st;
      rdata  = rd;
      cs_x   = 1'b0;
      tick(1);
      a0 = a0v;
      push(K_RD, exp);
      rd_x = 1'b0;
      tick(SYNC_STG + 2);
      chk("rd_oe_drive", dat_oe, 1'b1);
      chk("rd_dat_o", dat_o, exp);
      tick(len - (SYNC_STG + 2));
      if (a0v) push(K_ACK, 8'h00);
      rd_x = 1'b1;
      tick(SYNC_STG + 3);
      chk("rd_oe_release", dat_oe, 1'b0);
      cs_x = 1'b1;
      tick(2);
   endtask

   task automatic short_write();
      cs_x = 1'b0;
      tick(1);
      push(K_ERR, 8'h00);
      wr_x = 1'b0;
      tick(1);
      wr_x = 1'b1;
      tick(SYNC_STG + 4);
      cs_x = 1'b1;
      tick(2);
   endtask

   initial begin
      int kind;
      // reset state
      tick(3);
      chk("rst_dat_o", dat_o, 8'h00);
      chk("rst_dat_oe", dat_oe, 1'b0);
      chk("rst_cmd_we", cmd_we, 1'b0);
      chk("rst_dat_we", dat_we, 1'b0);
      chk("rst_wdata", wdata, 8'h00);
      chk("rst_rd_ack", rd_ack, 1'b0);
      chk("rst_bus_err", bus_err, 1'b0);
      rst_x = 1'b1;
      tick(4);

      // T1 command write
      host_write(1'b1, 8'h40, 6);
      chk("t1_wdata_held", wdata, 8'h40);
      // T2 data writes
      host_write(1'b0, 8'hA5, 5);
      host_write(1'b0, 8'h5A, 5);
      chk("t2_wdata_held", wdata, 8'h5A);
      // T3 status read, T4 data read
      host_read(1'b0, 8'h60, 8'h11, 6);
      host_read(1'b1, 8'h22, 8'h3C, 6);

      // T5 short write and both strobes low together
      short_write();
      cs_x = 1'b0;
      tick(1);
      push(K_ERR, 8'h00);
      rd_x = 1'b0;
      wr_x = 1'b0;
      tick(SYNC_STG + 3);
      chk("t5_both_oe", dat_oe, 1'b0);
      rd_x = 1'b1;
      wr_x = 1'b1;
      tick(SYNC_STG + 3);
      cs_x = 1'b1;
      tick(2);

      // write strobe dropping during a read
      status = 8'h77;
      cs_x = 1'b0;
      tick(1);
      a0 = 1'b0;
      push(K_RD, 8'h77);
      rd_x = 1'b0;
      tick(SYNC_STG + 3);
      push(K_ERR, 8'h00);
      wr_x = 1'b0;
      tick(SYNC_STG + 3);
      chk("rd_wr_err_oe", dat_oe, 1'b0);
      rd_x = 1'b1;
      wr_x = 1'b1;
      tick(SYNC_STG + 3);
      cs_x = 1'b1;
      tick(2);

      // chip select released while the write byte is held
      cs_x = 1'b0;
      tick(1);
      a0    = 1'b1;
      dat_i = 8'hC3;
      wr_x  = 1'b0;
      tick(CAP_DLY + 5);
      push(K_ERR, 8'h00);
      cs_x = 1'b1;
      tick(SYNC_STG + 3);
      wr_x = 1'b1;
      tick(SYNC_STG + 3);

      // T6 reset in the middle of a held write
      cs_x = 1'b0;
      tick(1);
      a0    = 1'b1;
      dat_i = 8'h99;
      wr_x  = 1'b0;
      tick(CAP_DLY + 5);
      rst_x = 1'b0;
      #1;
      chk("t6_wdata", wdata, 8'h00);
      chk("t6_cmd_we", cmd_we, 1'b0);
      chk("t6_dat_oe", dat_oe, 1'b0);
      wr_x = 1'b1;
      cs_x = 1'b1;
      tick(3);
      rst_x = 1'b1;
      tick(SYNC_STG + 6);
      host_write(1'b1, 8'h81, 6);
      chk("t6_wdata_81", wdata, 8'h81);

      // randomized transactions
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: host_write(1'b1, 8'($urandom), $urandom_range(CAP_DLY + 2, CAP_DLY + 6));
            1: host_write(1'b0, 8'($urandom), $urandom_range(CAP_DLY + 2, CAP_DLY + 6));
            2: host_read(1'b0, 8'($urandom), 8'($urandom), $urandom_range(SYNC_STG + 3, 9));
            3: host_read(1'b1, 8'($urandom), 8'($urandom), $urandom_range(SYNC_STG + 3, 9));
            default: short_write();
         endcase
         tick($urandom_range(1, 4));
      end

      tick(10);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
